updi_transaction_handler: RTL and testbench

UPDI_TRANSACTION_HANDLER -- requirements
Module: updi_transaction_handler

---
 rtl/updi_pkg.sv | 24 ++
 rtl/updi_ack_timer.sv | 28 ++
 rtl/updi_transaction_handler.sv | 179 +++++++++++++++++
 tb/tb_updi_transaction_handler.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/updi_pkg.sv
// Shared UPDI transaction handler definitions: FSM states, protocol bytes and
// a sizing helper for index registers.
package updi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNCH,
    ST_OPCODE,
    ST_DATA,
    ST_ACK_RD,
    ST_ACK_CHK,
    ST_RX_RD,
    ST_RX_CHK
  } state_t;

  localparam logic [7:0] UPDI_SYNCH = 8'h55;
  localparam logic [7:0] UPDI_ACK   = 8'h40;

  // Bits needed to address n entries, never less than one.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/updi_ack_timer.sv
// Wait-state watchdog for the UPDI handler: counts empty-FIFO cycles while a
// read is awaited and flags expiry on the ACK_TIMEOUT-th such cycle.
module updi_ack_timer #(
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  input  logic empty,
  output logic expired_c
);

  localparam int unsigned CNT_BITS = $clog2(ACK_TIMEOUT + 1);

  logic [CNT_BITS-1:0] cnt;

  assign expired_c = waiting && empty && (cnt == CNT_BITS'(ACK_TIMEOUT - 1));

  // Leaving the wait state clears the count, so every entry starts from zero.
  always_ff @(posedge clk) begin
    if (rst || !waiting) begin
      cnt <= '0;
    end else if (empty && !expired_c) begin
      cnt <= cnt + CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/updi_transaction_handler.sv
// UPDI transaction sequencer: SYNCH, opcode, payload with optional ACK waits,
// then response capture. Define UPDI_ACK_TIMEOUT_EN to bound each RX wait.
module updi_transaction_handler
  import updi_pkg::*;
#(
  parameter int unsigned MAX_TX_DATA = 16,
  parameter int unsigned MAX_RX_DATA = 16,
  parameter int unsigned ACK_TIMEOUT = 1024,
  localparam int unsigned TX_LEN_BITS = $clog2(MAX_TX_DATA + 1),
  localparam int unsigned RX_LEN_BITS = $clog2(MAX_RX_DATA + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     ready,
  output logic                     done,
  output logic                     error,
  input  logic [7:0]               opcode,
  input  logic [8*MAX_TX_DATA-1:0] tx_data,
  input  logic [TX_LEN_BITS-1:0]   tx_len,
  input  logic [MAX_TX_DATA-1:0]   wait_ack_after,
  input  logic [RX_LEN_BITS-1:0]   rx_len,
  output logic [8*MAX_RX_DATA-1:0] rx_data,
  output logic [RX_LEN_BITS-1:0]   rx_count,
  output logic [7:0]               tx_fifo_data,
  output logic                     tx_fifo_wr_en,
  input  logic                     tx_fifo_full,
  input  logic [7:0]               rx_fifo_data,
  output logic                     rx_fifo_rd_en,
  input  logic                     rx_fifo_empty
);

  localparam int unsigned TX_IDX_BITS = idx_bits(MAX_TX_DATA);
  localparam int unsigned RX_IDX_BITS = idx_bits(MAX_RX_DATA);
  localparam logic [TX_LEN_BITS-1:0] TX_MAX = TX_LEN_BITS'(MAX_TX_DATA);
  localparam logic [RX_LEN_BITS-1:0] RX_MAX = RX_LEN_BITS'(MAX_RX_DATA);

  if (ACK_TIMEOUT == 0) begin : g_bad_ack_timeout
    $error("ACK_TIMEOUT must be nonzero");
  end

  state_t                   state;
  logic [7:0]               opcode_q;
  logic [8*MAX_TX_DATA-1:0] tx_data_q;
  logic [TX_LEN_BITS-1:0]   tx_len_q;
  logic [MAX_TX_DATA-1:0]   wack_q;
  logic [RX_LEN_BITS-1:0]   rx_len_q;
  logic [TX_IDX_BITS-1:0]   idx;
  logic                     tx_last;
  logic                     waiting;
  logic                     timeout;

  assign ready   = (state == ST_IDLE);
  assign waiting = (state == ST_ACK_RD) || (state == ST_RX_RD);
  assign tx_last = (TX_LEN_BITS'(idx) + TX_LEN_BITS'(1)) >= tx_len_q;

  // FIFO strobes are gated by rst so no byte moves in the reset cycle.
  assign tx_fifo_wr_en = !rst && !tx_fifo_full &&
                         ((state == ST_SYNCH) || (state == ST_OPCODE) || (state == ST_DATA));
  assign rx_fifo_rd_en = !rst && waiting && !rx_fifo_empty;

  always_comb begin
    tx_fifo_data = 8'h00;
    case (state)
      ST_SYNCH:  tx_fifo_data = UPDI_SYNCH;
      ST_OPCODE: tx_fifo_data = opcode_q;
      ST_DATA:   tx_fifo_data = tx_data_q[{idx, 3'b000} +: 8];
      default:   tx_fifo_data = 8'h00;
    endcase
  end

`ifdef UPDI_ACK_TIMEOUT_EN
  updi_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_ack_timer (
    .clk      (clk),
    .rst      (rst),
    .waiting  (waiting),
    .empty    (rx_fifo_empty),
    .expired_c(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      done      <= 1'b0;
      error     <= 1'b0;
      rx_count  <= '0;
      rx_data   <= '0;
      idx       <= '0;
      opcode_q  <= '0;
      tx_data_q <= '0;
      tx_len_q  <= '0;
      wack_q    <= '0;
      rx_len_q  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            opcode_q  <= opcode;
            tx_data_q <= tx_data;
            tx_len_q  <= (tx_len > TX_MAX) ? TX_MAX : tx_len;
            wack_q    <= wait_ack_after;
            rx_len_q  <= (rx_len > RX_MAX) ? RX_MAX : rx_len;
            error     <= 1'b0;
            rx_count  <= '0;
            rx_data   <= '0;
            idx       <= '0;
            state     <= ST_SYNCH;
          end
        end
        ST_SYNCH: begin
          if (tx_fifo_wr_en) state <= ST_OPCODE;
        end
        ST_OPCODE: begin
          if (tx_fifo_wr_en) begin
            if (tx_len_q == '0) begin
              state <= (rx_len_q != '0) ? ST_RX_RD : ST_IDLE;
              done  <= (rx_len_q == '0);
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (tx_fifo_wr_en) begin
            if (wack_q[idx]) begin
              state <= ST_ACK_RD;
            end else if (tx_last) begin
              state <= (rx_len_q != '0) ? ST_RX_RD : ST_IDLE;
              done  <= (rx_len_q == '0);
            end else begin
              idx <= idx + TX_IDX_BITS'(1);
            end
          end
        end
        ST_ACK_RD, ST_RX_RD: begin
          if (rx_fifo_rd_en) begin
            state <= (state == ST_ACK_RD) ? ST_ACK_CHK : ST_RX_CHK;
          end else if (timeout) begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        ST_ACK_CHK: begin
          // idx still points at the byte that requested this ACK.
          if (rx_fifo_data != UPDI_ACK) begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= ST_IDLE;
          end else if (tx_last) begin
            state <= (rx_len_q != '0) ? ST_RX_RD : ST_IDLE;
            done  <= (rx_len_q == '0);
          end else begin
            idx   <= idx + TX_IDX_BITS'(1);
            state <= ST_DATA;
          end
        end
        ST_RX_CHK: begin
          rx_data[{RX_IDX_BITS'(rx_count), 3'b000} +: 8] <= rx_fifo_data;
          rx_count <= rx_count + RX_LEN_BITS'(1);
          if ((rx_count + RX_LEN_BITS'(1)) == rx_len_q) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end else begin
            state <= ST_RX_RD;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_updi_transaction_handler.sv
// Scoreboard bench for updi_transaction_handler with TX/RX FIFO models.
module tb_updi_transaction_handler;

  typedef struct packed {
    logic         err;
    logic [4:0]   cnt;
    logic [127:0] data;
  } done_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         ready, done, error;
  logic [7:0]   opcode = 8'h00;
  logic [127:0] tx_data = '0;
  logic [4:0]   tx_len = '0;
  logic [15:0]  wait_ack_after = '0;
  logic [4:0]   rx_len = '0;
  logic [127:0] rx_data;
  logic [4:0]   rx_count;
  logic [7:0]   tx_fifo_data;
  logic         tx_fifo_wr_en, tx_fifo_full;
  logic [7:0]   rx_fifo_data = 8'h00;
  logic         rx_fifo_rd_en, rx_fifo_empty;

  int n_cmp = 0;
  int n_bad = 0;

  // TX FIFO model, depth 4, optionally drained one byte per cycle
  logic [7:0] tx_mem [4];
  int   tx_cnt = 0, tx_wp = 0, tx_rp = 0;
  logic drain = 1'b1;
  logic force_full = 1'b0;

  // RX FIFO model: stimulus advances rx_wr, the model advances rx_rd
  logic [7:0] rx_mem [64];
  int   rx_wr = 0, rx_rd = 0;

  byte unsigned exp_tx[$];
  done_t        exp_done[$];

  updi_transaction_handler #(
    .MAX_TX_DATA(16),
    .MAX_RX_DATA(16),
    .ACK_TIMEOUT(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .ready         (ready),
    .done          (done),
    .error         (error),
    .opcode        (opcode),
    .tx_data       (tx_data),
    .tx_len        (tx_len),
    .wait_ack_after(wait_ack_after),
    .rx_len        (rx_len),
    .rx_data       (rx_data),
    .rx_count      (rx_count),
    .tx_fifo_data  (tx_fifo_data),
    .tx_fifo_wr_en (tx_fifo_wr_en),
    .tx_fifo_full  (tx_fifo_full),
    .rx_fifo_data  (rx_fifo_data),
    .rx_fifo_rd_en (rx_fifo_rd_en),
    .rx_fifo_empty (rx_fifo_empty)
  );

  always #5 clk = ~clk;

  assign tx_fifo_full  = force_full || (tx_cnt == 4);
  assign rx_fifo_empty = (rx_rd == rx_wr);

  always @(posedge clk) begin
    logic push, pop;
    push = tx_fifo_wr_en && !tx_fifo_full;
    pop  = drain && (tx_cnt > 0);
    if (push) begin
      tx_mem[tx_wp % 4] <= tx_fifo_data;
      tx_wp <= tx_wp + 1;
    end
    if (pop) tx_rp <= tx_rp + 1;
    tx_cnt <= tx_cnt + (push ? 1 : 0) - (pop ? 1 : 0);
  end

  always @(posedge clk) begin
    if (rx_fifo_rd_en) begin
      rx_fifo_data <= rx_mem[rx_rd % 64];
      rx_rd <= rx_rd + 1;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Monitors sample on the falling edge, away from DUT updates
  always @(negedge clk) begin
    if (tx_fifo_wr_en && !tx_fifo_full) begin
      if (exp_tx.size() == 0) fail("tx_unexpected", $sformatf("byte %0h written", tx_fifo_data));
      else chk("tx_byte", tx_fifo_data, exp_tx.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && done) begin
      chk("done_ready", ready, 1'b1);
      if (exp_done.size() == 0) begin
        fail("done_unexpected", "done pulse with no transaction expected");
      end else begin
        done_t e;
        e = exp_done.pop_front();
        chk("done_error", error, e.err);
        chk("done_rx_count", rx_count, e.cnt);
        chk("done_rx_data", rx_data, e.data);
      end
    end
  end

  task automatic push_tx(input byte unsigned b);
    exp_tx.push_back(b);
  endtask

  task automatic push_done(input logic e, input logic [4:0] c, input logic [127:0] d);
    done_t r;
    r.err = e; r.cnt = c; r.data = d;
    exp_done.push_back(r);
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_mem[rx_wr % 64] = b;
    rx_wr++;
  endtask

  task automatic run(input logic [7:0] op, input logic [31:0] d, input int len,
                     input logic [15:0] wack, input int rlen);
    opcode = op;
    tx_data = '0;
    tx_data[31:0] = d;
    tx_len = 5'(len);
    wait_ack_after = wack;
    rx_len = 5'(rlen);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_ready(input string name, input int max, output int cycles);
    cycles = 0;
    while (!ready && cycles < max) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (!ready) fail(name, "ready never returned");
  endtask

  task automatic wait_tx_left(input string name, input int left, input int max);
    int k = 0;
    while (exp_tx.size() > left && k < max) begin
      @(posedge clk); #1;
      k++;
    end
    if (exp_tx.size() > left) fail(name, "expected TX bytes not written");
  endtask

  task automatic wait_fifo_cnt(input string name, input int target, input int max);
    int k = 0;
    while (tx_cnt != target && k < max) begin
      @(posedge clk); #1;
      k++;
    end
    if (tx_cnt != target) fail(name, "TX FIFO level not reached");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_rx_count", rx_count, 5'd0);
    chk("rst_rx_data", rx_data, 128'h0);
    chk("rst_wr_en", tx_fifo_wr_en, 1'b0);
    chk("rst_rd_en", rx_fifo_rd_en, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Opcode only: FIFO must hold exactly SYNCH and opcode
    drain = 1'b0;
    push_tx(8'h55); push_tx(8'hE5);
    push_done(1'b0, 5'd0, 128'h0);
    run(8'hE5, 32'h0, 0, 16'h0, 0);
    wait_ready("t029_done", 50, cyc);
    chk("t029_fifo_cnt", tx_cnt, 2);
    chk("t029_fifo0", tx_mem[tx_rp % 4], 8'h55);
    chk("t029_fifo1", tx_mem[(tx_rp + 1) % 4], 8'hE5);
    drain = 1'b1;

    // Payload with ACKs after bytes 1 and 3, FIFO held full at the start
    force_full = 1'b1;
    push_tx(8'h55); push_tx(8'h45); push_tx(8'h12);
    push_tx(8'h34); push_tx(8'h56); push_tx(8'h78);
    push_done(1'b0, 5'd0, 128'h0);
    run(8'h45, 32'h78563412, 4, 16'b1010, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t030_stall_wr", tx_fifo_wr_en, 1'b0);
    end
    @(posedge clk); #1;
    force_full = 1'b0;
    wait_tx_left("t030_first4", 2, 50);
    repeat (10) @(posedge clk);
    #1;
    chk("t030_ack_wait_ready", ready, 1'b0);
    chk("t030_ack_wait_tx", exp_tx.size(), 2);
    chk("t030_ack_wait_rd", rx_fifo_rd_en, 1'b0);
    push_rx(8'h40);
    wait_tx_left("t030_last2", 0, 50);
    repeat (5) @(posedge clk);
    #1;
    chk("t030_ack2_wait", ready, 1'b0);
    push_rx(8'h40);
    wait_ready("t030_done", 50, cyc);

    // Bad ACK aborts; the following ACK byte stays in the FIFO
    push_tx(8'h55); push_tx(8'h44); push_tx(8'h99);
    push_done(1'b1, 5'd0, 128'h0);
    push_rx(8'h00); push_rx(8'h40);
    run(8'h44, 32'h99, 1, 16'h0001, 0);
    wait_ready("t031_done", 50, cyc);
    chk("t031_error", error, 1'b1);
    chk("t031_rx_left", rx_wr - rx_rd, 1);
    rx_wr = rx_rd;

    // Response capture with tx_len=0 and all ACK bits set (ignored)
    push_tx(8'h55); push_tx(8'h24);
    push_done(1'b0, 5'd2, 128'hCDAB);
    push_rx(8'hAB); push_rx(8'hCD);
    run(8'h24, 32'h0, 0, 16'hFFFF, 2);
    wait_ready("t032_done", 50, cyc);
    chk("t032_rx_count", rx_count, 5'd2);
    chk("t032_error", error, 1'b0);

    // Reset while stalled in DATA, then a clean transaction
    drain = 1'b0;
    push_tx(8'h55); push_tx(8'h11); push_tx(8'hA1); push_tx(8'hB2);
    run(8'h11, 32'hC3B2A1, 3, 16'h0, 0);
    wait_fifo_cnt("t033_fill", 4, 50);
    repeat (3) @(posedge clk);
    #1;
    chk("t033_stalled", ready, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t033_rst_ready", ready, 1'b1);
    chk("t033_rst_wr_en", tx_fifo_wr_en, 1'b0);
    chk("t033_rst_error", error, 1'b0);
    chk("t033_rst_done", done, 1'b0);
    rst = 1'b0;
    drain = 1'b1;
    @(posedge clk); #1;
    chk("t033_post_wr_en", tx_fifo_wr_en, 1'b0);
    wait_fifo_cnt("t033_drain", 0, 20);
    push_tx(8'h55); push_tx(8'h22); push_tx(8'h5A);
    push_done(1'b0, 5'd0, 128'h0);
    run(8'h22, 32'h5A, 1, 16'h0, 0);
    wait_ready("t033_fresh_done", 50, cyc);

    // Missing ACK: bounded with the timer, indefinite without it
    push_tx(8'h55); push_tx(8'h66); push_tx(8'h77);
`ifdef UPDI_ACK_TIMEOUT_EN
    push_done(1'b1, 5'd0, 128'h0);
    run(8'h66, 32'h77, 1, 16'h0001, 0);
    wait_ready("t034_timeout", 200, cyc);
    chk("t034_cycles", cyc, 11);
    chk("t034_error", error, 1'b1);
`else
    run(8'h66, 32'h77, 1, 16'h0001, 0);
    repeat (100) @(posedge clk);
    #1;
    chk("t034_still_waiting", ready, 1'b0);
    chk("t034_no_read", rx_fifo_rd_en, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t034_rst_ready", ready, 1'b1);
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("sb_tx_drained", exp_tx.size(), 0);
    chk("sb_done_drained", exp_done.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
